// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//   Multi-cycle 8-bit unsigned multiply (shift-add) and divide (restoring)
//   sequencer. It has no adder of its own: each step borrows the shared ALU
//   through alu_a/alu_b/alu_op and folds alu_c/alu_flags[0] back into its
//   registers in the same cycle.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   request pulse, sampled only in IDLE
//   op_div     in   0 = MUL, 1 = DIV (sampled with start)
//   opnd_a     in   multiplicand / dividend
//   opnd_b     in   multiplier / divisor
//   alu_c      in   ALU result
//   alu_flags  in   ALU flags, bit 0 = carry / borrow
//   alu_a      out  ALU operand a (0 when not owned)
//   alu_b      out  ALU operand b (0 when not owned)
//   alu_op     out  ALU opcode (OP_ADD when not owned)
//   alu_own    out  1 while stepping MUL or DIV
//   busy       out  1 while stepping MUL or DIV
//   done       out  one-cycle completion pulse
//   div_zero   out  DIV by zero indicator, valid with done
//   result_hi  out  MUL product[15:8] / DIV remainder
//   result_lo  out  MUL product[7:0]  / DIV quotient
// -----------------------------------------------------------------------------
module muldiv_seq #(
   parameter logic [3:0] OP_ADD = 4'h0,
   parameter logic [3:0] OP_SUB = 4'h1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       op_div,
   input  logic [7:0] opnd_a,
   input  logic [7:0] opnd_b,
   input  logic [7:0] alu_c,
   input  logic [7:0] alu_flags,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_op,
   output logic       alu_own,
   output logic       busy,
   output logic       done,
   output logic       div_zero,
   output logic [7:0] result_hi,
   output logic [7:0] result_lo
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t     r_state;
   logic [2:0] r_cnt;
   logic [7:0] r_hi;      // MUL: product high half, DIV: partial remainder
   logic [7:0] r_lo;      // MUL: multiplier / product low half, DIV: quotient
   logic [7:0] r_m;       // MUL: multiplicand, DIV: divisor
   logic       r_dz;

   state_t     w_state_next;
   logic [2:0] w_cnt_next;
   logic [7:0] w_hi_next;
   logic [7:0] w_lo_next;
   logic [7:0] w_m_next;
   logic       w_dz_next;
   logic [7:0] w_t;
   logic       w_cf;
   logic       w_unused_flags;

   // Only the carry flag matters; the rest of the flag bus is ignored.
   assign w_cf           = alu_flags[0];
   assign w_unused_flags = ^alu_flags[7:1];

   // Restoring divide: shift the next dividend bit into the remainder.
   assign w_t = {r_hi[6:0], r_lo[7]};

   assign result_hi = r_hi;
   assign result_lo = r_lo;
   assign div_zero  = r_dz;

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_hi_next    = r_hi;
      w_lo_next    = r_lo;
      w_m_next     = r_m;
      w_dz_next    = r_dz;
      alu_a        = 8'h00;
      alu_b        = 8'h00;
      alu_op       = OP_ADD;
      alu_own      = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_cnt_next = 3'd0;
               w_dz_next  = 1'b0;
               if (!op_div) begin
                  w_hi_next    = 8'h00;
                  w_lo_next    = opnd_b;
                  w_m_next     = opnd_a;
                  w_state_next = S_MUL;
               end else if (opnd_b != 8'h00) begin
                  w_hi_next    = 8'h00;
                  w_lo_next    = opnd_a;
                  w_m_next     = opnd_b;
                  w_state_next = S_DIV;
               end else begin
                  // Divide by zero finishes immediately without using the ALU.
                  w_hi_next    = opnd_a;
                  w_lo_next    = 8'hFF;
                  w_dz_next    = 1'b1;
                  w_state_next = S_DONE;
               end
            end
         end

         S_MUL: begin
            alu_own = 1'b1;
            busy    = 1'b1;
            alu_a   = r_hi;
            alu_b   = r_m;
            alu_op  = OP_ADD;
            // The 17-bit {CF, sum, lo} is shifted right by one; the carry
            // lands in hi[7] so no product bit is lost.
            if (r_lo[0]) begin
               w_hi_next = {w_cf, alu_c[7:1]};
               w_lo_next = {alu_c[0], r_lo[7:1]};
            end else begin
               w_hi_next = {1'b0, r_hi[7:1]};
               w_lo_next = {r_hi[0], r_lo[7:1]};
            end
            w_cnt_next = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
               w_state_next = S_DONE;
            end
         end

         S_DIV: begin
            alu_own = 1'b1;
            busy    = 1'b1;
            alu_a   = w_t;
            alu_b   = r_m;
            alu_op  = OP_SUB;
            // rem[7] set means the shifted value is really 9 bits wide and
            // therefore always >= divisor; the 8-bit difference is still exact.
            if (r_hi[7] || !w_cf) begin
               w_hi_next = alu_c;
               w_lo_next = {r_lo[6:0], 1'b1};
            end else begin
               w_hi_next = w_t;
               w_lo_next = {r_lo[6:0], 1'b0};
            end
            w_cnt_next = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
               w_state_next = S_DONE;
            end
         end

         S_DONE: begin
            done         = 1'b1;
            w_state_next = S_IDLE;
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 3'd0;
         r_hi    <= 8'h00;
         r_lo    <= 8'h00;
         r_m     <= 8'h00;
         r_dz    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_hi    <= w_hi_next;
         r_lo    <= w_lo_next;
         r_m     <= w_m_next;
         r_dz    <= w_dz_next;
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
//   Self-checking bench for muldiv_seq. Provides a behavioural shared ALU and
//   compares every operation against plain arithmetic (a*b, a/b, a%b).
// -----------------------------------------------------------------------------
module tb_muldiv_seq;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;

   logic       clk;
   logic       reset;
   logic       start;
   logic       op_div;
   logic [7:0] opnd_a;
   logic [7:0] opnd_b;
   logic [7:0] alu_c;
   logic [7:0] alu_flags;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [3:0] alu_op;
   logic       alu_own;
   logic       busy;
   logic       done;
   logic       div_zero;
   logic [7:0] result_hi;
   logic [7:0] result_lo;

   int n_checks = 0;
   int n_errors = 0;

   muldiv_seq #(.OP_ADD(OP_ADD), .OP_SUB(OP_SUB)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op_div    (op_div),
      .opnd_a    (opnd_a),
      .opnd_b    (opnd_b),
      .alu_c     (alu_c),
      .alu_flags (alu_flags),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_own   (alu_own),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .result_hi (result_hi),
      .result_lo (result_lo)
   );

   // Shared ALU model. Upper flag bits carry junk to show they are ignored.
   logic [8:0] alu_sum;
   assign alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
   assign alu_c     = (alu_op == OP_SUB) ? (alu_a - alu_b) : alu_sum[7:0];
   assign alu_flags = {7'h55, (alu_op == OP_SUB) ? (alu_a < alu_b) : alu_sum[8]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Runs one operation from the idle state. With hold=1, start stays high and
   // the operand inputs keep changing until done is seen.
   task automatic do_op(input logic div, input logic [7:0] a, input logic [7:0] b,
                        input logic hold);
      logic [7:0] exp_hi, exp_lo;
      logic       exp_dz;
      logic [15:0] prod;
      int exp_lat, exp_own;
      int cycles, own, extra_done;
      bit got;

      if (!div) begin
         prod    = 16'(a) * 16'(b);
         exp_hi  = prod[15:8];
         exp_lo  = prod[7:0];
         exp_dz  = 1'b0;
         exp_lat = 9;
         exp_own = 8;
      end else if (b != 8'd0) begin
         exp_hi  = a % b;
         exp_lo  = a / b;
         exp_dz  = 1'b0;
         exp_lat = 9;
         exp_own = 8;
      end else begin
         exp_hi  = a;
         exp_lo  = 8'hFF;
         exp_dz  = 1'b1;
         exp_lat = 1;
         exp_own = 0;
      end

      @(negedge clk);
      start  = 1'b1;
      op_div = div;
      opnd_a = a;
      opnd_b = b;
      cycles = 0;
      own    = 0;
      got    = 0;
      while (!got && cycles < 30) begin
         @(posedge clk);
         @(negedge clk);
         cycles++;
         if (hold) begin
            op_div = 1'($urandom);
            opnd_a = 8'($urandom);
            opnd_b = 8'($urandom);
         end else begin
            start = 1'b0;
         end
         if (alu_own) own++;
         if (done) got = 1;
      end
      start = 1'b0;

      chk("done_seen", 32'(got), 32'd1);
      chk("latency", 32'(cycles), 32'(exp_lat));
      chk("alu_own_cycles", 32'(own), 32'(exp_own));
      chk("result_hi", 32'(result_hi), 32'(exp_hi));
      chk("result_lo", 32'(result_lo), 32'(exp_lo));
      chk("div_zero", 32'(div_zero), 32'(exp_dz));
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("own_at_done", 32'(alu_own), 32'd0);

      extra_done = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) extra_done++;
      end
      chk("single_done", 32'(extra_done), 32'd0);
      chk("hold_result", 32'({result_hi, result_lo}), 32'({exp_hi, exp_lo}));

      $display("%s a=%0d b=%0d hold=%0d -> hi=%02h lo=%02h dz=%0d lat=%0d",
               div ? "DIV" : "MUL", a, b, hold, result_hi, result_lo, div_zero, cycles);
   endtask

   initial begin
      int leftover_done;
      logic       r_div;
      logic [7:0] r_a, r_b;

      reset  = 1'b1;
      start  = 1'b0;
      op_div = 1'b0;
      opnd_a = 8'h00;
      opnd_b = 8'h00;

      // Reset state
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_own", 32'(alu_own), 32'd0);
      chk("rst_result", 32'({result_hi, result_lo}), 32'd0);
      chk("rst_dz", 32'(div_zero), 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'(OP_ADD));
      chk("rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
      reset = 1'b0;

      // Directed cases
      do_op(1'b0, 8'd13, 8'd11, 1'b0);
      do_op(1'b0, 8'd255, 8'd255, 1'b0);
      do_op(1'b0, 8'd0, 8'd200, 1'b0);
      do_op(1'b1, 8'd200, 8'd7, 1'b0);
      do_op(1'b1, 8'd255, 8'd1, 1'b0);
      do_op(1'b1, 8'd5, 8'd9, 1'b0);
      do_op(1'b1, 8'd77, 8'd0, 1'b0);
      do_op(1'b0, 8'd6, 8'd7, 1'b0);
      chk("dz_cleared", 32'(div_zero), 32'd0);

      // start held with changing operands during a MUL and a DIV
      do_op(1'b0, 8'd100, 8'd3, 1'b1);
      do_op(1'b1, 8'd250, 8'd13, 1'b1);

      // Asynchronous reset at step 4 of a DIV
      @(negedge clk);
      start  = 1'b1;
      op_div = 1'b1;
      opnd_a = 8'd200;
      opnd_b = 8'd7;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("pre_rst_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_own", 32'(alu_own), 32'd0);
      chk("arst_result", 32'({result_hi, result_lo}), 32'd0);
      chk("arst_alu_op", 32'(alu_op), 32'(OP_ADD));
      @(negedge clk);
      reset = 1'b0;
      leftover_done = 0;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) leftover_done++;
      end
      chk("abandoned_op", 32'(leftover_done), 32'd0);
      $display("RESET mid-DIV -> busy=%0d hi=%02h lo=%02h", busy, result_hi, result_lo);
      do_op(1'b0, 8'd3, 8'd5, 1'b0);

      // Randomized operations
      for (int i = 0; i < 40; i++) begin
         r_div = 1'($urandom);
         r_a   = 8'($urandom);
         r_b   = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
         do_op(r_div, r_a, r_b, 1'($urandom_range(0, 3) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
